// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//
// Contents:
//   uart_state_e  : frame state encoding (IDLE/START/DATA/STOP)
//   OVS_MID       : sample-counter value at the middle of a bit (16x oversampling)
//   OVS_LAST      : sample-counter value at the last sample of a bit
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_e;

  localparam logic [3:0] OVS_MID  = 4'd7;
  localparam logic [3:0] OVS_LAST = 4'd15;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous input bit.
//
// Parameters:
//   RESET_VAL : value both flops take while rst_n is low
// Ports:
//   clk   in  : destination clock
//   rst_n in  : asynchronous active-low reset
//   d     in  : asynchronous input
//   q     out : synchronized copy of d, two clk edges late
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/receiver.sv
// receiver -- 8N1 UART receiver with 16x oversampling.
//
// Ports:
//   clk       in      : sole clock, rising edge
//   rst_n     in      : asynchronous active-low reset
//   rx        in      : serial line (asynchronous, idle high)
//   enb       in      : 16x-baud sample tick, one clk wide
//   rdy_clr   in      : consumer acknowledge, clears rdy and overrun
//   data_out  out [8] : last good received byte
//   rdy       out     : data_out holds an unread byte
//   frame_err out     : last frame ended with stop bit = 0
//   overrun   out     : sticky, a good byte completed while rdy was still set
//   busy      out     : a frame is in progress (state != IDLE)
//
// Handshake: rdy rises on the clk edge that samples a good stop bit and stays
// high until rdy_clr is seen on a clk edge. A good stop landing on the same
// edge as rdy_clr wins (rdy stays 1) but does not flag overrun.
module receiver
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       enb,
  input  logic       rdy_clr,
  output logic [7:0] data_out,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        fe_q, fe_d;
  logic        ovr_q, ovr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;

    // Acknowledge acts regardless of enb; a good stop below may override rdy.
    if (rdy_clr) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enb && !rx_s) begin
          state_d = ST_START;
          cnt_d   = 4'd0;
        end
      end

      ST_START: begin
        if (enb) begin
          if (cnt_q == OVS_MID) begin
            cnt_d = 4'd0;
            if (!rx_s) begin
              state_d = ST_DATA;
              idx_d   = 3'd0;
            end else begin
              // Start bit not low at mid-bit: treat as a glitch.
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (enb) begin
          if (cnt_q == OVS_LAST) begin
            shift_d[idx_q] = rx_s;
            cnt_d          = 4'd0;
            if (idx_q == 3'd7) begin
              state_d = ST_STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      ST_STOP: begin
        if (enb) begin
          if (cnt_q == OVS_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            if (rx_s) begin
              data_d = shift_q;
              rdy_d  = 1'b1;
              fe_d   = 1'b0;
              if (rdy_q && !rdy_clr) begin
                ovr_d = 1'b1;
              end
            end else begin
              fe_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign rdy       = rdy_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule : receiver

// File: tb/tb_receiver.sv
// tb_receiver -- directed self-checking bench for the UART receiver.
module tb_receiver;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       enb;
  logic       rdy_clr;
  logic [7:0] data_out;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp;
  int n_bad;
  logic busy_at_155;

  receiver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .enb       (enb),
    .rdy_clr   (rdy_clr),
    .data_out  (data_out),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    rx      = 1'b1;
    enb     = 1'b0;
    rdy_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One enb tick: rx has three clk edges to cross the synchronizer first.
  // Returns on the negedge right after the tick edge.
  task automatic tick(input logic clr);
    repeat (3) @(negedge clk);
    enb     = 1'b1;
    rdy_clr = clr;
    @(negedge clk);
    enb     = 1'b0;
    rdy_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
  endtask

  // Drive n_ticks ticks of a frame (tick 0 = start-bit falling edge seen).
  // A full frame is 160 ticks followed by 16 idle ticks.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int n_ticks, input logic clr_at_stop);
    int seg;
    for (int i = 0; i < n_ticks; i++) begin
      seg = i / 16;
      if (seg == 0)      rx = 1'b0;
      else if (seg <= 8) rx = b[seg-1];
      else               rx = stop_bit;
      tick(clr_at_stop && (i == 152));
      if (i == 155) busy_at_155 = busy;
    end
    if (n_ticks >= 160) begin
      rx = 1'b1;
      for (int i = 0; i < 16; i++) tick(1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    busy_at_155 = 1'b0;
    rst_n = 1'b0;
    rx = 1'b1;
    enb = 1'b0;
    rdy_clr = 1'b0;
    do_reset();

    // Reset values
    check_eq("rst_data", data_out, 8'h00);
    check_eq("rst_rdy", {7'd0, rdy}, 8'd0);
    check_eq("rst_fe", {7'd0, frame_err}, 8'd0);
    check_eq("rst_ovr", {7'd0, overrun}, 8'd0);
    check_eq("rst_busy", {7'd0, busy}, 8'd0);

    // Good byte A5
    send_frame(8'hA5, 1'b1, 160, 1'b0);
    check_eq("a5_data", data_out, 8'hA5);
    check_eq("a5_rdy", {7'd0, rdy}, 8'd1);
    check_eq("a5_fe", {7'd0, frame_err}, 8'd0);
    check_eq("a5_ovr", {7'd0, overrun}, 8'd0);
    check_eq("a5_idle_after_stop", {7'd0, busy_at_155}, 8'd0);

    // Glitch: 4 low ticks, START rejects at T8
    do_reset();
    rx = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0);
    rx = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0);
    check_eq("glitch_busy_t7", {7'd0, busy}, 8'd1);
    tick(1'b0);
    check_eq("glitch_busy_t8", {7'd0, busy}, 8'd0);
    check_eq("glitch_rdy", {7'd0, rdy}, 8'd0);
    check_eq("glitch_fe", {7'd0, frame_err}, 8'd0);

    // Bad stop: 3C with stop=0; line stays low past T152 so START retriggers
    send_frame(8'h3C, 1'b0, 160, 1'b0);
    check_eq("bad_fe", {7'd0, frame_err}, 8'd1);
    check_eq("bad_rdy", {7'd0, rdy}, 8'd0);
    check_eq("bad_data", data_out, 8'h00);
    check_eq("bad_retrigger", {7'd0, busy_at_155}, 8'd1);
    check_eq("bad_busy_end", {7'd0, busy}, 8'd0);

    // Overrun: 11 then 22, no acknowledge (also clears frame_err)
    send_frame(8'h11, 1'b1, 160, 1'b0);
    check_eq("b11_data", data_out, 8'h11);
    check_eq("b11_fe", {7'd0, frame_err}, 8'd0);
    check_eq("b11_ovr", {7'd0, overrun}, 8'd0);
    send_frame(8'h22, 1'b1, 160, 1'b0);
    check_eq("ovr_data", data_out, 8'h22);
    check_eq("ovr_rdy", {7'd0, rdy}, 8'd1);
    check_eq("ovr_ovr", {7'd0, overrun}, 8'd1);
    pulse_clr();
    check_eq("clr_rdy", {7'd0, rdy}, 8'd0);
    check_eq("clr_ovr", {7'd0, overrun}, 8'd0);
    check_eq("clr_data", data_out, 8'h22);

    // Acknowledge on the same edge as the second byte's stop sample
    do_reset();
    send_frame(8'h11, 1'b1, 160, 1'b0);
    send_frame(8'h22, 1'b1, 160, 1'b1);
    check_eq("same_rdy", {7'd0, rdy}, 8'd1);
    check_eq("same_ovr", {7'd0, overrun}, 8'd0);
    check_eq("same_data", data_out, 8'h22);

    // Reset at T80 aborts the frame
    send_frame(8'hFF, 1'b1, 80, 1'b0);
    check_eq("mid_busy_pre", {7'd0, busy}, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check_eq("mid_rst_data", data_out, 8'h00);
    check_eq("mid_rst_rdy", {7'd0, rdy}, 8'd0);
    check_eq("mid_rst_busy", {7'd0, busy}, 8'd0);
    check_eq("mid_rst_fe", {7'd0, frame_err}, 8'd0);
    check_eq("mid_rst_ovr", {7'd0, overrun}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b0);
    check_eq("post_rst_idle", {7'd0, busy}, 8'd0);
    check_eq("post_rst_rdy", {7'd0, rdy}, 8'd0);
    send_frame(8'h5A, 1'b1, 160, 1'b0);
    check_eq("b5a_data", data_out, 8'h5A);
    check_eq("b5a_rdy", {7'd0, rdy}, 8'd1);
    check_eq("b5a_fe", {7'd0, frame_err}, 8'd0);

    // enb low freezes the FSM; acknowledge still acts
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("freeze_busy", {7'd0, busy}, 8'd0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    pulse_clr();
    check_eq("freeze_clr_rdy", {7'd0, rdy}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_receiver

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 The block SHALL have no parameters; 16x oversampling and 8N1 framing (8 data bits, no parity, 1 stop bit) are fixed.
REQ-002 clk  input  1  sole clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 enb  input  1  16x-baud sample tick, one clk wide; logic advances only on enb=1.
REQ-006 rdy_clr  input  1  consumer acknowledge; clears rdy and overrun.
REQ-007 data_out  output  8  last good received byte.
REQ-008 rdy  output  1  data_out holds an unread byte.
REQ-009 frame_err  output  1  last frame had stop bit = 0.
REQ-010 overrun  output  1  sticky: a good byte completed while rdy was still 1.
REQ-011 busy  output  1  high whenever state != IDLE (combinational).

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s) before use; synchronizer flops reset to 1.
REQ-013 State machine SHALL have four states: IDLE, START, DATA, STOP; internal 4-bit sample counter cnt, 3-bit bit index idx, 8-bit shift register.
REQ-014 IDLE: on enb with rx_s=0 -> START, cnt=0. Otherwise remain.
REQ-015 START: on enb, if cnt=7, evaluate rx_s: 0 -> DATA with cnt=0, idx=0; 1 -> IDLE (glitch rejected, no flag change). Otherwise cnt+1.
REQ-016 DATA: on enb, if cnt=15, store rx_s at bit idx (LSB first), cnt=0; then idx=7 -> STOP, else idx+1. Otherwise cnt+1.
REQ-017 STOP: on enb, if cnt=15, evaluate rx_s and go to IDLE; otherwise cnt+1.
REQ-018 Good stop (rx_s=1): data_out<=shift register, rdy<=1, frame_err<=0, overrun<=1 if rdy was 1 and rdy_clr=0 that cycle.
REQ-019 Bad stop (rx_s=0): frame_err<=1; data_out, rdy, overrun unchanged.
REQ-020 Latency: with the falling edge of rx_s seen on enb tick T0, bits are sampled on ticks T24+16k (k=0..7), the stop bit on T152; rdy/data_out update on the clk edge of T152.
REQ-021 rdy_clr=1 SHALL clear rdy and overrun on the next edge; if a good stop completes in the same cycle, rdy=1 and the new byte wins, and overrun=0.
REQ-022 enb=0 SHALL freeze state, cnt, idx and shift register; rdy_clr still acts.
REQ-023 Line held low after a bad stop (break) SHALL retrigger START from IDLE on the next low-sampled enb; no lockout.
REQ-024 Only the four encoded states SHALL be reachable; any illegal encoding SHALL go to IDLE on the next edge.

Reset
REQ-025 While rst_n=0: state=IDLE, cnt=0, idx=0, shift register=0, data_out=8'h00, rdy=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; after release the block waits in IDLE for a new falling edge.

Structure
REQ-027 State encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and constants OVS_MID=7, OVS_LAST=15 SHALL reside in a shared uart package also used by the transmitter.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value parameterizable, here 1).

Verification
REQ-029 Byte 8'hA5, 16 enb per bit -> data_out=8'hA5, rdy=1, frame_err=0 on tick T152.
REQ-030 Low pulse of 4 enb ticks on idle line -> returns to IDLE at T8, busy pulses, rdy stays 0.
REQ-031 Byte 8'h3C with stop bit forced 0 -> frame_err=1, rdy=0, data_out unchanged (8'h00 after reset).
REQ-032 Two bytes 8'h11 then 8'h22, no rdy_clr -> data_out=8'h22, rdy=1, overrun=1; then rdy_clr -> rdy=0, overrun=0.
REQ-033 rdy_clr asserted on the same clk as the second byte's stop sample -> rdy=1, overrun=0, data_out=8'h22.
REQ-034 rst_n pulsed low at T80 of a frame -> all outputs at reset values, busy=0; next full frame 8'h5A received correctly.
